// File: rtl/paper_sequencer_if.sv
// Program RAM bus between the paper sequencer and its combinational-read RAM.
// The sequencer drives the address, and the RAM returns the word in the same cycle.
interface paper_sequencer_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_addr, input mem_rdata);
   modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/paper_sequencer.sv
// Fetch/decode/execute controller for the 2-bit paper processor (INC / JNO / HLT / NOP).
// Owns pc, ir, accumulator, overflow flag and a saturating retired-instruction counter.
module paper_sequencer #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2,
   parameter int CNT_W  = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   paper_sequencer_if.master  memBus,
   output logic [DATA_W-1:0]  acc_o,
   output logic               ovf_o,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               busy_o,
   output logic               halted_o,
   output logic               illegal_o,
   output logic [CNT_W-1:0]   instr_count_o
);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPERAND, HALT} state_e;

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_JNO = 2'b01;
   localparam logic [1:0] OP_HLT = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  instrCount_q, instrCount_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              retire;
   logic [DATA_W:0]   incSum;
   logic [ADDR_W-1:0] pcPlusOne;

   assign incSum    = {1'b0, acc_q} + {{DATA_W{1'b0}}, 1'b1};
   assign pcPlusOne = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         ir_q         <= '0;
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         instrCount_q <= '0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         instrCount_q <= instrCount_d;
         busy_q       <= busy_d;
         halted_q     <= halted_d;
         illegal_q    <= illegal_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      acc_d        = acc_q;
      ovf_d        = ovf_q;
      instrCount_d = instrCount_q;
      retire       = 1'b0;

      unique case (state_q)
         IDLE, HALT: begin
            if (start_i) begin
               pc_d         = '0;
               acc_d        = '0;
               ovf_d        = 1'b0;
               instrCount_d = '0;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            ir_d    = memBus.mem_rdata;
            pc_d    = pcPlusOne;
            state_d = DECODE;
         end
         DECODE: begin
            unique case (ir_q[1:0])
               OP_INC: begin
                  acc_d   = incSum[DATA_W-1:0];
                  ovf_d   = incSum[DATA_W];
                  retire  = 1'b1;
                  state_d = FETCH;
               end
               OP_JNO: state_d = OPERAND;
               OP_HLT: begin
                  retire  = 1'b1;
                  state_d = HALT;
               end
               OP_ILL: begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         OPERAND: begin
            // Branch target is the low bits of the word following the JNO opcode
            pc_d    = ovf_q ? pcPlusOne : memBus.mem_rdata[ADDR_W-1:0];
            retire  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase

      if (retire && (instrCount_q != {CNT_W{1'b1}})) begin
         instrCount_d = instrCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      // Status flags are registered from the next state so they line up with it
      busy_d    = (state_d == FETCH) || (state_d == DECODE) || (state_d == OPERAND);
      halted_d  = (state_d == HALT);
      illegal_d = (state_q == FETCH) && (memBus.mem_rdata[1:0] == OP_ILL);
   end

   assign memBus.mem_addr = pc_q;
   assign acc_o           = acc_q;
   assign ovf_o           = ovf_q;
   assign pc_o            = pc_q;
   assign busy_o          = busy_q;
   assign halted_o        = halted_q;
   assign illegal_o       = illegal_q;
   assign instr_count_o   = instrCount_q;

endmodule

// File: tb/tb_paper_sequencer.sv
// Self-checking bench for paper_sequencer: an instruction-level program model builds the
// expected per-cycle trace, plus directed programs with hand-computed expectations.
module tb_paper_sequencer;

   logic       clk;
   logic       rstN;
   logic       start;
   logic [1:0] acc;
   logic       ovf;
   logic [1:0] pc;
   logic       busy;
   logic       halted;
   logic       illegal;
   logic [7:0] cnt;
   logic [1:0] ram [4];

   int checks = 0;
   int errors = 0;
   bit chkEn  = 1'b0;

   paper_sequencer_if #(.ADDR_W(2), .DATA_W(2)) memIf ();

   assign memIf.mem_rdata = ram[memIf.mem_addr];

   paper_sequencer #(.ADDR_W(2), .DATA_W(2), .CNT_W(8)) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .start_i       (start),
      .memBus        (memIf),
      .acc_o         (acc),
      .ovf_o         (ovf),
      .pc_o          (pc),
      .busy_o        (busy),
      .halted_o      (halted),
      .illegal_o     (illegal),
      .instr_count_o (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] pc;
      logic [1:0] acc;
      logic       ovf;
      logic [7:0] cnt;
      logic       busy;
      logic       halted;
      logic       illegal;
   } obs_t;

   obs_t expQ [$];
   obs_t expCur;

   function automatic obs_t mk(input logic [1:0] p, input logic [1:0] a, input logic o,
                               input logic [7:0] c, input logic b, input logic h, input logic il);
      obs_t r;
      r.pc = p; r.acc = a; r.ovf = o; r.cnt = c; r.busy = b; r.halted = h; r.illegal = il;
      return r;
   endfunction

   function automatic logic [7:0] satInc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Runs the program at instruction level from a cleared machine; each instruction
   // contributes one observation per cycle it occupies (2 for INC/HLT/NOP, 3 for JNO).
   task automatic genTrace();
      logic [1:0] p = 2'd0;
      logic [1:0] a = 2'd0;
      logic       o = 1'b0;
      logic [7:0] c = 8'd0;
      logic [1:0] p1;
      logic [1:0] op;
      expQ.delete();
      expQ.push_back(mk(p, a, o, c, 1'b1, 1'b0, 1'b0));
      for (int n = 0; n < 60; n++) begin
         op = ram[p];
         p1 = p + 2'd1;
         expQ.push_back(mk(p1, a, o, c, 1'b1, 1'b0, op == 2'b11));
         if (op == 2'b10) begin
            c = satInc(c);
            expQ.push_back(mk(p1, a, o, c, 1'b0, 1'b1, 1'b0));
            break;
         end
         if (op == 2'b00) begin
            {o, a} = {1'b0, a} + 3'd1;
            p = p1;
         end else if (op == 2'b01) begin
            expQ.push_back(mk(p1, a, o, c, 1'b1, 1'b0, 1'b0));
            p = o ? p1 + 2'd1 : ram[p1];
         end else begin
            p = p1;
         end
         c = satInc(c);
         expQ.push_back(mk(p, a, o, c, 1'b1, 1'b0, 1'b0));
      end
   endtask

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         expQ.delete();
         expCur <= mk(2'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      end else if (expQ.size() > 0) begin
         expCur <= expQ.pop_front();
      end else if (start) begin
         genTrace();
         expCur <= expQ.pop_front();
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         obs_t act;
         act = mk(pc, acc, ovf, cnt, busy, halted, illegal);
         checks++;
         if ((act !== expCur) || (memIf.mem_addr !== expCur.pc)) begin
            errors++;
            $display("[TB] FAIL cycleModel t=%0t: got pc=%0d addr=%0d acc=%0d ovf=%0b cnt=%0d busy=%0b halted=%0b ill=%0b, expected pc=%0d acc=%0d ovf=%0b cnt=%0d busy=%0b halted=%0b ill=%0b",
                     $time, act.pc, memIf.mem_addr, act.acc, act.ovf, act.cnt, act.busy, act.halted,
                     act.illegal, expCur.pc, expCur.acc, expCur.ovf, expCur.cnt, expCur.busy,
                     expCur.halted, expCur.illegal);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Pulses start so that it is sampled at the next rising edge (E0), returning just after E0.
   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic loadRam(input logic [1:0] w0, input logic [1:0] w1,
                          input logic [1:0] w2, input logic [1:0] w3);
      ram[0] = w0; ram[1] = w1; ram[2] = w2; ram[3] = w3;
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   logic [1:0] accHist [$];
   int         illCycles;

   // Counts edges after E0 until halted rises, with a bounded budget.
   task automatic runToHalt(input int budget, output int edges);
      logic [1:0] prevAcc;
      prevAcc   = acc;
      edges     = 0;
      illCycles = 0;
      accHist.delete();
      while (!halted && edges < budget) begin
         @(posedge clk);
         #1;
         edges++;
         if (illegal) illCycles++;
         if (acc != prevAcc) accHist.push_back(acc);
         prevAcc = acc;
      end
      if (!halted) begin
         errors++;
         checks++;
         $display("[TB] FAIL haltTimeout: got halted=0 after %0d edges, expected halted=1", edges);
      end
   endtask

   initial begin
      int edges;
      start = 1'b0;
      rstN  = 1'b0;
      loadRam(2'b00, 2'b01, 2'b00, 2'b10);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetPc", pc, 0);
      checkOutput("resetAddr", memIf.mem_addr, 0);
      checkOutput("resetAcc", acc, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetHalted", halted, 0);
      checkOutput("resetCnt", cnt, 0);
      @(negedge clk);
      rstN  = 1'b1;
      chkEn = 1'b1;

      $display("[TB] case 1: INC/JNO loop");
      applyStimulus();
      runToHalt(200, edges);
      checkOutput("c1Edges", edges, 22);
      checkOutput("c1Acc", acc, 0);
      checkOutput("c1Ovf", ovf, 1);
      checkOutput("c1Pc", pc, 0);
      checkOutput("c1Cnt", cnt, 9);
      checkOutput("c1AccSteps", accHist.size(), 4);
      if (accHist.size() == 4) begin
         checkOutput("c1Acc0", accHist[0], 1);
         checkOutput("c1Acc1", accHist[1], 2);
         checkOutput("c1Acc2", accHist[2], 3);
         checkOutput("c1Acc3", accHist[3], 0);
      end

      $display("[TB] case 2: immediate HLT and restart");
      loadRam(2'b10, 2'b00, 2'b00, 2'b00);
      applyStimulus();
      runToHalt(50, edges);
      checkOutput("c2Edges", edges, 2);
      checkOutput("c2Pc", pc, 1);
      checkOutput("c2Acc", acc, 0);
      checkOutput("c2Cnt", cnt, 1);
      applyStimulus();
      checkOutput("c2RestartPc", pc, 0);
      checkOutput("c2RestartCnt", cnt, 0);
      checkOutput("c2RestartBusy", busy, 1);
      runToHalt(50, edges);
      checkOutput("c2RestartEdges", edges, 2);
      checkOutput("c2RestartCnt2", cnt, 1);

      $display("[TB] case 3: illegal opcode");
      loadRam(2'b11, 2'b00, 2'b10, 2'b00);
      applyStimulus();
      runToHalt(50, edges);
      checkOutput("c3IllCycles", illCycles, 1);
      checkOutput("c3Acc", acc, 1);
      checkOutput("c3Cnt", cnt, 3);
      checkOutput("c3Edges", edges, 6);

      $display("[TB] case 4: pc wrap and overflow");
      loadRam(2'b00, 2'b00, 2'b00, 2'b11);
      applyStimulus();
      repeat (7) @(posedge clk);
      #1;
      checkOutput("c4PcWrap", pc, 0);
      checkOutput("c4BusyWrap", busy, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("c4Acc4th", acc, 0);
      checkOutput("c4Ovf4th", ovf, 1);
      checkOutput("c4Cnt4th", cnt, 5);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("c4Acc5th", acc, 1);
      checkOutput("c4Ovf5th", ovf, 0);
      doReset();

      $display("[TB] case 5: reset during OPERAND");
      loadRam(2'b00, 2'b01, 2'b00, 2'b10);
      applyStimulus();
      repeat (4) @(posedge clk);
      #2;
      checkOutput("c5PreAcc", acc, 1);
      rstN  = 1'b0;
      start = 1'b1;
      #1;
      checkOutput("c5Acc", acc, 0);
      checkOutput("c5Pc", pc, 0);
      checkOutput("c5Cnt", cnt, 0);
      checkOutput("c5Busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("c5BusyHeld", busy, 0);
      checkOutput("c5PcHeld", pc, 0);
      @(negedge clk);
      start = 1'b0;
      #2 rstN = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("c5IdleBusy", busy, 0);

      $display("[TB] case 6: start while busy");
      applyStimulus();
      edges = 0;
      while (!halted && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
         start = (edges == 3 || edges == 4 || edges == 9 || edges == 15);
      end
      start = 1'b0;
      checkOutput("c6Edges", edges, 22);
      checkOutput("c6Cnt", cnt, 9);
      checkOutput("c6Acc", acc, 0);
      checkOutput("c6Ovf", ovf, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("c6StillHalted", halted, 1);

      chkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/paper_sequencer.md
Name: paper_sequencer

Overview:
- Fetch/decode/execute controller for the 2-bit paper processor.
- Owns the program counter, instruction register, accumulator and overflow flag.
- Drives the address of the combinational-read program RAM and sequences the INC / JNO / HLT instruction set.
- Sits between the testbench/top level (start/status) and the program RAM, replacing the free-running counter-driven address path.

Parameters:
ADDR_W, 2, program address width; PC wraps modulo 2^ADDR_W.
DATA_W, 2, RAM word and accumulator width; must be >= ADDR_W and >= 2.
CNT_W, 8, width of the retired-instruction counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  run request, sampled only in IDLE or HALT.
mem_addr  output  ADDR_W  program RAM address.
mem_rdata  input  DATA_W  RAM read data, valid combinationally in the same cycle as mem_addr.
acc  output  DATA_W  accumulator.
ovf  output  1  overflow flag.
pc  output  ADDR_W  program counter.
busy  output  1  high in FETCH, DECODE and OPERAND.
halted  output  1  high in HALT.
illegal  output  1  one-cycle pulse on opcode 11.
instr_count  output  CNT_W  retired instructions, saturating.

Behaviour:
- Encoding: opcode = mem_rdata[1:0]. 00 = INC, 01 = JNO (target in next word, low ADDR_W bits), 10 = HLT, 11 = NOP plus illegal pulse.
- Reset (reset = 0, asynchronous): state = IDLE; pc, acc, ovf, instr_count, ir = 0; busy, halted, illegal = 0; mem_addr = 0.
- mem_addr = pc in every state.
- IDLE: on start = 1, clear pc, acc, ovf and instr_count, then go to FETCH.
- HALT: halted = 1. On start = 1, clear the same registers and go to FETCH. Otherwise hold all registers.
- start is ignored while busy.
- FETCH: ir <= mem_rdata; pc <= pc + 1 (wraps); go to DECODE.
- DECODE, INC: {carry, acc} <= acc + 1; ovf <= carry, so ovf is rewritten on every INC (11 -> 00 sets it, any other value clears it). Go to FETCH. Total 2 cycles.
- DECODE, JNO: go to OPERAND. acc and ovf unchanged.
- DECODE, HLT: go to HALT; pc stays at HLT address + 1. Total 2 cycles.
- DECODE, 11: illegal = 1 for this cycle only; go to FETCH. Total 2 cycles.
- OPERAND (JNO second word): if ovf = 0, pc <= mem_rdata[ADDR_W-1:0]; else pc <= pc + 1. Go to FETCH. Total 3 cycles. JNO never modifies ovf.
- instr_count increments by 1 on leaving DECODE for INC, HLT and NOP, and on leaving OPERAND for JNO. It saturates at 2^CNT_W - 1.
- PC wrap: pc + 1 at 2^ADDR_W - 1 gives 0. A JNO whose opcode sits at the last address reads its operand from address 0.
- Simultaneous start and reset: reset wins.
- Reset mid-instruction: immediate return to IDLE; no partial update survives.
- All outputs are registered except mem_addr, which equals pc.

Test Plan:
1. RAM = {00,01,00,10}; pulse start at edge E0. Required: acc sequence 1,2,3,0; JNO taken three times, then not taken. halted rises after edge E0+22 with acc = 00, ovf = 1, pc = 00, instr_count = 9.
2. RAM = {10,xx,xx,xx}; pulse start. Required: halted high 2 edges after start, pc = 01, acc = 00, instr_count = 1. Then pulse start again: run restarts from pc = 0 and instr_count is cleared.
3. RAM = {11,00,10,xx}. Required: illegal high exactly one cycle (DECODE of address 0); acc = 01 at halt; instr_count = 3.
4. RAM = {00,00,00,11}, with 11 at address 3 acting as NOP. Required: pc wraps 3 -> 0 and execution continues. acc goes 1,2,3, then 11 -> 00 with ovf = 1 on the 4th INC. ovf clears on the 5th INC (acc = 01).
5. Assert reset low mid-OPERAND of case 1. Required: immediately state = IDLE, acc/pc/ovf/instr_count = 0, busy = 0. start is ignored while reset is low.
6. Assert start while busy. Required: no effect on the trace, instr_count or timing versus case 1.
